// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: NB_DATA_OUT data bits, optional odd/even parity, 1 or 2 stop bits.
// Define UART_RX_MAJORITY_EN to take each bit decision as a 2-of-3 vote over consecutive samples.
module uart_rx_cfg #(
  parameter int BAUD_RATE   = 115200,
  parameter int CLOCK_FREQ  = 10000000,
  parameter int NB_DATA_OUT = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   i_data,
  output logic                   o_valid,
  output logic [NB_DATA_OUT-1:0] o_data,
  output logic                   o_parity_err,
  output logic                   o_frame_err
);

  localparam int N_CYCLES = (CLOCK_FREQ + BAUD_RATE/2) / BAUD_RATE;
  localparam int HALF     = (N_CYCLES - 1) >> 1;
  localparam int CW       = $clog2(N_CYCLES);
  localparam int IW       = $clog2(NB_DATA_OUT);

  localparam logic [CW-1:0] C_LAST = CW'(N_CYCLES - 1);
  localparam logic [CW-1:0] C_HALF = CW'(HALF);
  localparam logic [IW-1:0] I_DLAST = IW'(NB_DATA_OUT - 1);
  localparam logic [IW-1:0] I_SLAST = IW'(STOP_BITS - 1);

  if (N_CYCLES < 8 || NB_DATA_OUT < 5 || NB_DATA_OUT > 9 || PARITY_MODE < 0 ||
      PARITY_MODE > 2 || (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_cfg_err
    $error("uart_rx_cfg: illegal parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE
  } state_t;

  logic                   r_sync1, r_rx_s;
  state_t                 r_state, w_state_nxt;
  logic [CW-1:0]          r_cnt, w_cnt_nxt;
  logic [IW-1:0]          r_idx, w_idx_nxt;
  logic                   r_armed, w_armed_nxt;
  logic [NB_DATA_OUT-1:0] r_shift, w_shift_nxt;
  logic                   r_perr, w_perr_nxt;
  logic                   r_ferr, w_ferr_nxt;
  logic                   r_valid, w_valid_nxt;
  logic [NB_DATA_OUT-1:0] r_data, w_data_nxt;
  logic                   r_operr, w_operr_nxt;
  logic                   r_oferr, w_oferr_nxt;
  logic                   w_bit;

`ifdef UART_RX_MAJORITY_EN
  localparam logic [CW-1:0] C_M3 = CW'(N_CYCLES - 3);
  localparam logic [CW-1:0] C_M2 = CW'(N_CYCLES - 2);
  localparam logic [CW-1:0] C_H2 = CW'(HALF - 2);
  localparam logic [CW-1:0] C_H1 = CW'(HALF - 1);

  logic r_v0, r_v1;

  // The two earlier votes are captured ahead of the decision cycle; the third is rx_s itself.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_v0 <= 1'b1;
      r_v1 <= 1'b1;
    end else begin
      if ((r_state == S_START) ? (r_cnt == C_H2) : (r_cnt == C_M3)) r_v0 <= r_rx_s;
      if ((r_state == S_START) ? (r_cnt == C_H1) : (r_cnt == C_M2)) r_v1 <= r_rx_s;
    end
  end

  assign w_bit = (r_v0 & r_v1) | (r_v0 & r_rx_s) | (r_v1 & r_rx_s);
`else
  assign w_bit = r_rx_s;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_armed_nxt = r_armed;
    w_shift_nxt = r_shift;
    w_perr_nxt  = r_perr;
    w_ferr_nxt  = r_ferr;
    w_valid_nxt = 1'b0;
    w_data_nxt  = r_data;
    w_operr_nxt = r_operr;
    w_oferr_nxt = r_oferr;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        w_idx_nxt = '0;
        // Arming needs the line seen high, so a held-low break never restarts a frame.
        if (!r_armed) begin
          if (r_rx_s) w_armed_nxt = 1'b1;
        end else if (!r_rx_s) begin
          w_state_nxt = S_START;
          w_armed_nxt = 1'b0;
        end
      end
      S_START: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == C_HALF) begin
          w_cnt_nxt = '0;
          if (!w_bit) begin
            w_state_nxt = S_DATA;
            w_idx_nxt   = '0;
            w_perr_nxt  = 1'b0;
            w_ferr_nxt  = 1'b0;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_DATA: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == C_LAST) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {w_bit, r_shift[NB_DATA_OUT-1:1]};
          if (r_idx == I_DLAST) begin
            w_idx_nxt   = '0;
            w_state_nxt = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
      S_PARITY: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == C_LAST) begin
          w_cnt_nxt   = '0;
          w_perr_nxt  = (PARITY_MODE != 0) && (((^r_shift) ^ w_bit) != (PARITY_MODE == 1));
          w_idx_nxt   = '0;
          w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == C_LAST) begin
          w_cnt_nxt  = '0;
          w_ferr_nxt = r_ferr | ~w_bit;
          if (r_idx == I_SLAST) begin
            // Outputs load on the edge entering DONE so o_valid is high during DONE.
            w_state_nxt = S_DONE;
            w_idx_nxt   = '0;
            w_valid_nxt = 1'b1;
            w_data_nxt  = r_shift;
            w_operr_nxt = r_perr;
            w_oferr_nxt = r_ferr | ~w_bit;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_armed <= 1'b0;
      r_shift <= '0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_operr <= 1'b0;
      r_oferr <= 1'b0;
    end else begin
      r_sync1 <= i_data;
      r_rx_s  <= r_sync1;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_armed <= w_armed_nxt;
      r_shift <= w_shift_nxt;
      r_perr  <= w_perr_nxt;
      r_ferr  <= w_ferr_nxt;
      r_valid <= w_valid_nxt;
      r_data  <= w_data_nxt;
      r_operr <= w_operr_nxt;
      r_oferr <= w_oferr_nxt;
    end
  end

  assign o_valid      = r_valid;
  assign o_data       = r_data;
  assign o_parity_err = r_operr;
  assign o_frame_err  = r_oferr;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboarded bench for uart_rx_cfg: an 8N1 instance and an 8E2 instance driven with directed frames.
module tb_uart_rx_cfg;
  localparam int N    = 87;
  localparam int HALF = 43;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx0 = 1'b1, rx1 = 1'b1;
  logic v0, v1, pe0, pe1, fe0, fe1;
  logic [7:0] d0, d1;
  longint cyc = 0;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    longint     at;
  } exp_t;

  exp_t q0[$], q1[$];
  exp_t m0, m1;

  uart_rx_cfg #(.BAUD_RATE(115200), .CLOCK_FREQ(10000000), .NB_DATA_OUT(8),
                .PARITY_MODE(0), .STOP_BITS(1)) u_dut0 (
    .clock(clk), .reset(rst), .i_data(rx0), .o_valid(v0), .o_data(d0),
    .o_parity_err(pe0), .o_frame_err(fe0));

  uart_rx_cfg #(.BAUD_RATE(115200), .CLOCK_FREQ(10000000), .NB_DATA_OUT(8),
                .PARITY_MODE(2), .STOP_BITS(2)) u_dut1 (
    .clock(clk), .reset(rst), .i_data(rx1), .o_valid(v1), .o_data(d1),
    .o_parity_err(pe1), .o_frame_err(fe1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (v0 === 1'b1) begin
      n_vec++;
      if (q0.size() == 0) begin
        n_err++;
        $display("FAIL dut0 unexpected o_valid at edge %0d data=%h", cyc, d0);
      end else begin
        m0 = q0.pop_front();
        if (d0 !== m0.d || pe0 !== m0.pe || fe0 !== m0.fe || cyc != m0.at) begin
          n_err++;
          $display("FAIL dut0 frame: got data=%h perr=%b ferr=%b edge=%0d, expected data=%h perr=%b ferr=%b edge=%0d",
                   d0, pe0, fe0, cyc, m0.d, m0.pe, m0.fe, m0.at);
        end
      end
    end
    if (v1 === 1'b1) begin
      n_vec++;
      if (q1.size() == 0) begin
        n_err++;
        $display("FAIL dut1 unexpected o_valid at edge %0d data=%h", cyc, d1);
      end else begin
        m1 = q1.pop_front();
        if (d1 !== m1.d || pe1 !== m1.pe || fe1 !== m1.fe || cyc != m1.at) begin
          n_err++;
          $display("FAIL dut1 frame: got data=%h perr=%b ferr=%b edge=%0d, expected data=%h perr=%b ferr=%b edge=%0d",
                   d1, pe1, fe1, cyc, m1.d, m1.pe, m1.fe, m1.at);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic set_line(input int sel, input logic v);
    if (sel == 0) rx0 = v;
    else rx1 = v;
  endtask

  // Every call starts and ends 1 time unit after a rising edge.
  task automatic hold(input int sel, input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      set_line(sel, v);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int sel, input logic [7:0] d, input bit par_en, input logic pbit,
                      input logic exp_pe, input int nstop, input logic stopv,
                      input int gl_bit, input int gl_off, input logic [7:0] exp_d);
    logic bits[12];
    int   nb;
    exp_t e;
    nb = 0;
    bits[nb] = 1'b0; nb++;
    for (int i = 0; i < 8; i++) begin bits[nb] = d[i]; nb++; end
    if (par_en) begin bits[nb] = pbit; nb++; end
    for (int i = 0; i < nstop; i++) begin bits[nb] = stopv; nb++; end
    e.d  = exp_d;
    e.pe = exp_pe;
    e.fe = ~stopv;
    e.at = cyc + 1 + 3 + HALF + longint'(nb - 1) * N;
    if (sel == 0) q0.push_back(e);
    else q1.push_back(e);
    for (int b = 0; b < nb; b++)
      for (int c = 0; c < N; c++) begin
        set_line(sel, bits[b] ^ ((b == gl_bit) && (c == gl_off)));
        @(posedge clk);
        #1;
      end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] glitch_exp;
    logic [7:0] pd;
`ifdef UART_RX_MAJORITY_EN
    glitch_exp = 8'hFF;
`else
    glitch_exp = 8'hFE;
`endif
    pd = 8'h3C;
    repeat (3) @(posedge clk);
    #1;
    check("reset o_valid", {31'b0, v0}, 0);
    check("reset o_data", {24'b0, d0}, 0);
    check("reset o_parity_err", {31'b0, pe0}, 0);
    check("reset o_frame_err", {31'b0, fe0}, 0);
    rst = 1'b0;
    hold(0, 1'b1, 20);

    send(0, 8'hA5, 0, 0, 0, 1, 1'b1, -1, 0, 8'hA5);
    hold(0, 1'b1, 10);

    // Abort a frame with a one-cycle reset during data bit 4.
    hold(0, 1'b0, N);
    for (int i = 0; i < 4; i++) hold(0, pd[i], N);
    hold(0, pd[4], N / 2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    rx0 = 1'b1;
    check("midframe reset o_valid", {31'b0, v0}, 0);
    check("midframe reset o_data", {24'b0, d0}, 0);
    check("midframe reset o_parity_err", {31'b0, pe0}, 0);
    check("midframe reset o_frame_err", {31'b0, fe0}, 0);
    hold(0, 1'b1, 3 * N);
    send(0, 8'h3C, 0, 0, 0, 1, 1'b1, -1, 0, 8'h3C);
    hold(0, 1'b1, 10);

    // Short low pulse: rejected at the start check.
    hold(0, 1'b0, 20);
    hold(0, 1'b1, 2 * N);
    send(0, 8'h3C, 0, 0, 0, 1, 1'b1, -1, 0, 8'h3C);

    send(0, 8'h12, 0, 0, 0, 1, 1'b1, -1, 0, 8'h12);
    send(0, 8'h34, 0, 0, 0, 1, 1'b1, -1, 0, 8'h34);
    hold(0, 1'b1, 10);

    // Stop bit low, then break for three frame times.
    send(0, 8'h55, 0, 0, 0, 1, 1'b0, -1, 0, 8'h55);
    hold(0, 1'b0, 30 * N);
    hold(0, 1'b1, 2 * N);
    send(0, 8'h3C, 0, 0, 0, 1, 1'b1, -1, 0, 8'h3C);
    hold(0, 1'b1, 10);

    // One-cycle low glitch landing on the data-bit-0 decision sample.
    send(0, 8'hFF, 0, 0, 0, 1, 1'b1, 1, HALF + 1, glitch_exp);
    hold(0, 1'b1, 10);

    send(1, 8'h03, 1, 1'b1, 1'b1, 2, 1'b1, -1, 0, 8'h03);
    hold(1, 1'b1, 10);
    send(1, 8'h03, 1, 1'b0, 1'b0, 2, 1'b1, -1, 0, 8'h03);
    hold(1, 1'b1, 10);
    send(1, 8'hB4, 1, 1'b1, 1'b1, 2, 1'b1, -1, 0, 8'hB4);

    hold(0, 1'b1, 200);
    check("dut0 frames still pending", q0.size(), 0);
    check("dut1 frames still pending", q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Parametrised UART receiver, next generation of the fixed 8N1 receiver. Configurable data width, parity mode and stop-bit count, with parity and framing error reporting and break-safe re-arming. It sits between the asynchronous serial pin and the byte-level consumer logic in the UART subsystem, with a single clock domain and a synchronous reset.

## Interface
- BAUD_RATE, 115200, line bit rate in bits/s
- CLOCK_FREQ, 10000000, clock frequency in Hz
- NB_DATA_OUT, 8, data bits per frame; legal range 5–9
- PARITY_MODE, 0, parity mode: 0 = none, 1 = odd, 2 = even
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2
- clock  input  1  system clock; all logic on the rising edge
- reset  input  1  synchronous reset, active-high
- i_data  input  1  asynchronous serial line; idle level is high
- o_valid  output  1  one-cycle pulse when a frame completes
- o_data  output  NB_DATA_OUT  received word, LSB is the first bit on the line
- o_parity_err  output  1  parity mismatch for the frame flagged by o_valid; 0 when PARITY_MODE = 0
- o_frame_err  output  1  a stop bit was sampled low in the frame flagged by o_valid

## Operation
- Derived constants:
  - N_CYCLES = (CLOCK_FREQ + BAUD_RATE/2) / BAUD_RATE, integer division (rounded).
  - HALF = (N_CYCLES-1) >> 1.
  - Counter width = $clog2(N_CYCLES).
  - Elaboration must fail if N_CYCLES < 8 or any parameter is outside its legal range.
- Input synchroniser: two flops on i_data; rx_s denotes the output of the second flop. Reset value of both flops is 1.
- State machine states: IDLE, START, DATA, PARITY, STOP, DONE.
- IDLE:
  - Counter and bit index are cleared.
  - An `armed` flag is set on the first cycle with rx_s = 1.
  - When armed and rx_s = 0: go to START with counter = 0, and clear `armed`.
- START:
  - Increment the counter each cycle.
  - At counter == HALF, evaluate the sample. If the sample is 0, go to DATA with counter = 0. Otherwise go to IDLE (glitch rejected, no output).
- Every later bit takes N_CYCLES cycles. The counter runs 0..N_CYCLES-1, and the bit is sampled on the cycle with counter == N_CYCLES-1; the counter then returns to 0.
- DATA:
  - Sample into shift/indexed register bit[idx], LSB first.
  - After NB_DATA_OUT bits, go to PARITY if PARITY_MODE != 0, else to STOP.
- PARITY:
  - Sample p.
  - Error condition is (XOR(data) ^ p) != (PARITY_MODE == 1). Odd mode: the total count of ones must be odd. Even mode: it must be even.
- STOP:
  - Sample STOP_BITS bits. Any sample of 0 sets the frame error.
  - After the last stop sample, go to DONE.
- DONE (one cycle):
  - Hold o_valid = 1 for exactly this cycle.
  - Update o_data, o_parity_err and o_frame_err, which hold until the next o_valid.
  - Go to IDLE.
- Framing-error recovery: after a frame error (for example a break, line held low), IDLE does not re-arm until rx_s has been seen high. No spurious frames are produced while the line stays low.
- Back-to-back frames: DONE is reached at mid-stop-bit, so a start edge immediately after the stop bit is accepted.
- Reset asserted in any state:
  - State goes to IDLE, counters to 0, `armed` to 0.
  - o_valid, o_data, o_parity_err and o_frame_err all go to 0.
  - A partial frame is discarded with no o_valid.

## Timing
- Let edge 0 be the clock edge that first captures i_data = 0 into the first synchroniser flop.
- START is entered at edge 2.
- The start check happens at edge 3+HALF.
- The sample for frame bit k (k = 1 for the first data bit) is taken at edge 3+HALF+k·N_CYCLES.
- Let B = NB_DATA_OUT + (PARITY_MODE != 0) + STOP_BITS.
- o_valid is registered high at edge 3+HALF+B·N_CYCLES, and low again at the next edge.
- With the default parameters, N_CYCLES = 87 and HALF = 43, so o_valid rises at edge 829 for 8N1.
- Enabling majority voting does not change any edge in this section.

## Configuration
- UART_RX_MAJORITY_EN defined: each sample is the 2-of-3 majority of rx_s.
  - Data, parity and stop bits: the three samples are taken at counter values N_CYCLES-3, N_CYCLES-2 and N_CYCLES-1.
  - Start check: the three samples are taken at counter values HALF-2, HALF-1 and HALF.
  - A single-cycle glitch is rejected.
- UART_RX_MAJORITY_EN undefined: a single sample of rx_s is taken at the decision cycle. No vote registers are generated.

## Test plan
- Default parameters, send 0xA5 8N1 → o_valid pulses for one cycle at edge 829; o_data = 0xA5, o_parity_err = 0, o_frame_err = 0.
- PARITY_MODE = 2, send 0x03 with parity bit = 1 → o_data = 0x03, o_parity_err = 1. Resend with parity bit = 0 → o_parity_err = 0.
- Send 0x55 with stop bit low, then hold the line low for 3 frame times → one o_valid with o_frame_err = 1, and no further o_valid until the line returns high and a new start is received.
- Drive i_data low for 20 cycles, then high → no o_valid; the next frame 0x3C is received correctly.
- Assert reset for 1 cycle during data bit 4 → no o_valid and all outputs 0; a following frame 0x3C gives o_data = 0x3C. Also send two frames 0x12 and 0x34 back-to-back with no idle gap → both are delivered, in order.
- Send 0xFF with a one-cycle low glitch on i_data exactly at the bit-0 decision cycle → o_data = 0xFF with UART_RX_MAJORITY_EN, and o_data = 0xFE without it.
